// File: rtl/lsu_queue_ptr_ctrl.sv
// Head/tail pointer and occupancy control for the LSU circular load/store queues.
// Optional macro LSU_Q_ALLOC_ON_POP_EN: allow allocation into a full queue in the cycle head retires.

module lsu_q_entry #(
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_all,
  input  logic             flush_valid,
  input  logic             set,
  input  logic             clr,
  input  logic [IDX_W-1:0] age,
  input  logic [IDX_W-1:0] keep_age,
  output logic             vld
);
  // A flush keeps entries no younger than the flush point; set wins over clr so a
  // full-queue pop+push onto the same slot leaves it occupied.
  always_ff @(posedge clk) begin
    if (reset)            vld <= 1'b0;
    else if (flush_all)   vld <= 1'b0;
    else if (flush_valid) vld <= vld & (age <= keep_age) & ~clr;
    else                  vld <= (vld & ~clr) | set;
  end
endmodule

module lsu_queue_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             commit,
  input  logic             flush_valid,
  input  logic [IDX_W-1:0] flush_idx,
  input  logic             flush_all,
  output logic [IDX_W-1:0] head,
  output logic [IDX_W-1:0] tail,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] entry_valid
);
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  logic             commit_ok, grant;
  logic [IDX_W-1:0] head_n, tail_n, keep_age;
  logic [IDX_W:0]   count_n;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign commit_ok = commit & ~empty;

`ifdef LSU_Q_ALLOC_ON_POP_EN
  assign alloc_ready = (~full | commit_ok) & ~flush_valid & ~flush_all;
`else
  assign alloc_ready = ~full & ~flush_valid & ~flush_all;
`endif

  assign grant     = alloc_valid & alloc_ready;
  assign alloc_idx = tail;
  // Age of the flush point relative to head; survivors have age <= keep_age.
  assign keep_age  = flush_idx - head;

  always_comb begin
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    if (flush_all) begin
      tail_n  = head;
      count_n = '0;
    end else if (flush_valid) begin
      tail_n  = flush_idx + IDX_W'(1);
      count_n = {1'b0, keep_age} + (IDX_W+1)'(1) - {{IDX_W{1'b0}}, commit_ok};
      if (commit_ok) head_n = head + IDX_W'(1);
    end else begin
      if (commit_ok) head_n = head + IDX_W'(1);
      if (grant)     tail_n = tail + IDX_W'(1);
      case ({grant, commit_ok})
        2'b10:   count_n = count + (IDX_W+1)'(1);
        2'b01:   count_n = count - (IDX_W+1)'(1);
        default: count_n = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [IDX_W-1:0] age;
    assign age = IDX_W'(i) - head;
    lsu_q_entry #(.IDX_W(IDX_W)) u_ent (
      .clk         (clk),
      .reset       (reset),
      .flush_all   (flush_all),
      .flush_valid (flush_valid),
      .set         (grant && (tail == IDX_W'(i))),
      .clr         (commit_ok && (head == IDX_W'(i))),
      .age         (age),
      .keep_age    (keep_age),
      .vld         (entry_valid[i])
    );
  end

  // Flushing to an unoccupied entry is a protocol violation.
  a_flush_idx_valid: assert property (@(posedge clk) disable iff (reset)
    (flush_valid && !flush_all) |-> entry_valid[flush_idx]);
  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count <= DEPTH_C);
  a_count_match: assert property (@(posedge clk) disable iff (reset)
    $countones(entry_valid) == int'(count));
endmodule

// File: tb/tb_lsu_queue_ptr_ctrl.sv
// Randomized scoreboard bench for lsu_queue_ptr_ctrl against a queue-of-indices model.
module tb_lsu_queue_ptr_ctrl;
  localparam int D = 8;
  localparam int W = 3;

  logic         clk = 1'b0, reset = 1'b1;
  logic         alloc_valid = 1'b0, commit = 1'b0, flush_valid = 1'b0, flush_all = 1'b0;
  logic [W-1:0] flush_idx = '0;
  logic         alloc_ready, full, empty;
  logic [W-1:0] alloc_idx, head, tail;
  logic [W:0]   count;
  logic [D-1:0] entry_valid;

  lsu_queue_ptr_ctrl #(.DEPTH(D)) dut (
    .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_idx(alloc_idx), .commit(commit), .flush_valid(flush_valid), .flush_idx(flush_idx),
    .flush_all(flush_all), .head(head), .tail(tail), .count(count), .full(full),
    .empty(empty), .entry_valid(entry_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ready;
    logic         grant;
    logic [W-1:0] idx;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [W:0]   count;
    logic         full;
    logic         empty;
    logic [D-1:0] valid;
  } exp_t;

  exp_t sb[$];
  int   q[$];      // occupied entry indices, oldest first
  int   m_head = 0;
  int   tests = 0, fails = 0;
  exp_t me;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit av, input bit cm, input bit fv,
                       input int fi, input bit fa);
    exp_t e;
    int   tl, p;
    bit   pop, rdy;
    @(negedge clk);
    reset = r; alloc_valid = av; commit = cm; flush_valid = fv;
    flush_idx = W'(fi); flush_all = fa;
    tl  = (m_head + q.size()) % D;
    pop = cm && (q.size() > 0);
`ifdef LSU_Q_ALLOC_ON_POP_EN
    rdy = (q.size() < D || pop) && !fv && !fa;
`else
    rdy = (q.size() < D) && !fv && !fa;
`endif
    e.ready = rdy;
    e.grant = av && rdy;
    e.idx   = W'(tl);
    if (r) begin
      q.delete(); m_head = 0;
    end else if (fa) begin
      q.delete();
    end else if (fv) begin
      p = -1;
      foreach (q[k]) if (q[k] == fi) p = k;
      while (q.size() > p + 1) void'(q.pop_back());
      if (pop) begin void'(q.pop_front()); m_head = (m_head + 1) % D; end
    end else begin
      if (pop) begin void'(q.pop_front()); m_head = (m_head + 1) % D; end
      if (e.grant) q.push_back(tl);
    end
    e.head  = W'(m_head);
    e.tail  = W'((m_head + q.size()) % D);
    e.count = (W+1)'(q.size());
    e.full  = (q.size() == D);
    e.empty = (q.size() == 0);
    e.valid = '0;
    foreach (q[k]) e.valid[q[k]] = 1'b1;
    sb.push_back(e);
  endtask

  // Monitor: combinational handshake before the edge, registered state after it.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        me = sb.pop_front();
        chk("alloc_ready", 32'(alloc_ready), 32'(me.ready));
        if (me.grant) chk("alloc_idx", 32'(alloc_idx), 32'(me.idx));
        @(posedge clk);
        #1;
        chk("head", 32'(head), 32'(me.head));
        chk("tail", 32'(tail), 32'(me.tail));
        chk("count", 32'(count), 32'(me.count));
        chk("full", 32'(full), 32'(me.full));
        chk("empty", 32'(empty), 32'(me.empty));
        chk("entry_valid", 32'(entry_valid), 32'(me.valid));
      end
    end
  end

  initial begin
    bit av, cm, fv, fa, r;
    int fi;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    // 1: eight allocs fill the queue, then a ninth is refused
    repeat (8) drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    // 2: three commits then three allocs wrap tail
    repeat (3) drive(0, 0, 1, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0, 0);
    // 3: reach head=6 tail=2, then flush to 7
    repeat (3) drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 7, 0);
    // 4: back to count=4, flush to head with commit empties the queue
    repeat (2) drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 6, 0);
    // 5: flush_all dominates alloc and commit
    repeat (5) drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 1);
    // 6: full queue, alloc with commit
    repeat (8) drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    // commit on empty is ignored
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      int phase;
      phase = (n / 300) % 3;
      r  = ($urandom % 300) == 0;
      av = ($urandom % 4) != 0;
      cm = (phase == 0) ? (($urandom % 4) == 0) :
           (phase == 1) ? (($urandom % 2) == 0) : (($urandom % 4) != 0);
      fv = (q.size() > 0) && (($urandom % 12) == 0);
      fi = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)] : 0;
      if (!fv) fi = int'($urandom % D);
      fa = ($urandom % 50) == 0;
      drive(r, av, cm, fv, fi, fa);
    end

    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
